// File: rtl/i2s_stream_tx.sv
// I2S transmitter: valid/ready frame FIFO, integer BCLK/LRCLK divider, MSB-first I2S framing.
// Optional underrun counter (underrun_cnt, cnt_clr) is enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_stream_tx #(
  parameter int SAMPLE_W      = 16,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int STEREO        = 1,
  parameter int UNDERRUN_HOLD = 1
) (
  input  logic                              clk_sys,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SAMPLE_W-1:0]               in_left,
  input  logic [SAMPLE_W-1:0]               in_right,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              underrun,
  output logic                              i2s_bclk,
  output logic                              i2s_lrclk,
  output logic                              i2s_data
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  input  logic                              cnt_clr,
  output logic [15:0]                       underrun_cnt
`endif
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int FRM_W = 2 * SAMPLE_W;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_lrclk;
  logic             r_data;
  logic             r_underrun;
  logic [FRM_W-1:0] r_held;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [FRM_W-1:0] r_mem [FIFO_DEPTH];

  logic                w_div_wrap;
  logic                w_fe;
  logic                w_frame_wrap;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [FRM_W-1:0]    w_push_frame;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic                w_lr_nxt;
  logic [BIT_W-1:0]    w_pos;
  logic [SAMPLE_W-1:0] w_word;
  logic [SAMPLE_W-1:0] w_shift;
  logic                w_data_nxt;

  assign w_div_wrap   = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_fe         = w_div_wrap & r_bclk;
  assign w_frame_wrap = w_fe & (r_bit_cnt == BIT_W'(2 * SLOT_BITS - 1));
  assign w_empty      = (r_level == LVL_W'(0));
  assign in_ready     = (r_level != LVL_W'(FIFO_DEPTH));
  assign w_push       = in_valid & in_ready;
  assign w_pop        = w_frame_wrap & ~w_empty;
  // Mono builds duplicate the left word so the right slot repeats it.
  assign w_push_frame = {in_left, (STEREO != 0) ? in_right : in_left};

  always_comb begin
    w_bit_nxt  = (r_bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) ? BIT_W'(0) : r_bit_cnt + BIT_W'(1);
    w_lr_nxt   = (w_bit_nxt >= BIT_W'(SLOT_BITS));
    w_pos      = w_lr_nxt ? (w_bit_nxt - BIT_W'(SLOT_BITS)) : w_bit_nxt;
    w_word     = w_lr_nxt ? r_held[SAMPLE_W-1:0] : r_held[FRM_W-1:SAMPLE_W];
    w_shift    = w_word >> (BIT_W'(SAMPLE_W) - w_pos);
    w_data_nxt = ((w_pos != BIT_W'(0)) && (w_pos <= BIT_W'(SAMPLE_W))) ? w_shift[0] : 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_frame;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_div_cnt  <= DIV_W'(0);
      r_bclk     <= 1'b0;
      r_bit_cnt  <= BIT_W'(0);
      r_lrclk    <= 1'b0;
      r_data     <= 1'b0;
      r_underrun <= 1'b0;
      r_held     <= FRM_W'(0);
      r_wr_ptr   <= PTR_W'(0);
      r_rd_ptr   <= PTR_W'(0);
      r_level    <= LVL_W'(0);
    end else begin
      r_div_cnt  <= w_div_wrap ? DIV_W'(0) : r_div_cnt + DIV_W'(1);
      r_bclk     <= w_div_wrap ? ~r_bclk : r_bclk;
      r_underrun <= w_frame_wrap & w_empty;
      if (w_fe) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_lr_nxt;
        r_data    <= w_data_nxt;
      end
      // The fetched frame serves the whole left+right period that starts now.
      if (w_pop) begin
        r_held <= r_mem[r_rd_ptr];
      end else if (w_frame_wrap && (UNDERRUN_HOLD == 0)) begin
        r_held <= FRM_W'(0);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign level     = r_level;
  assign underrun  = r_underrun;
  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_data  = r_data;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_ur_cnt;

  // Saturating count of underrun events; clear wins over increment.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_ur_cnt <= 16'h0000;
    end else if (cnt_clr) begin
      r_ur_cnt <= 16'h0000;
    end else if (w_frame_wrap && w_empty && (r_ur_cnt != 16'hFFFF)) begin
      r_ur_cnt <= r_ur_cnt + 16'h0001;
    end
  end

  assign underrun_cnt = r_ur_cnt;
`endif

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Directed bench for i2s_stream_tx: three instances (default, stereo/hold, mono/zero-fill).
module tb_i2s_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Instance A: stereo, hold on underrun, small FIFO, fast BCLK
  logic        a_rst_n, a_valid, a_ready, a_ur, a_bclk, a_lr, a_data;
  logic [15:0] a_left, a_right;
  logic [2:0]  a_level;
  // Instance B: mono, zero on underrun
  logic        b_rst_n, b_valid, b_ready, b_ur, b_bclk, b_lr, b_data;
  logic [15:0] b_left, b_right;
  logic [2:0]  b_level;
  // Instance D: default parameters
  logic        d_rst_n, d_valid, d_ready, d_ur, d_bclk, d_lr, d_data;
  logic [15:0] d_left, d_right;
  logic [3:0]  d_level;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic        a_cnt_clr, b_cnt_clr, d_cnt_clr;
  logic [15:0] a_cnt, b_cnt, d_cnt;
`endif

  i2s_stream_tx #(.SAMPLE_W(16), .SLOT_BITS(32), .BCLK_DIV(2), .FIFO_DEPTH(4),
                  .STEREO(1), .UNDERRUN_HOLD(1)) u_a (
    .clk_sys(clk), .reset_n(a_rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_left(a_left), .in_right(a_right), .level(a_level), .underrun(a_ur),
    .i2s_bclk(a_bclk), .i2s_lrclk(a_lr), .i2s_data(a_data)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .cnt_clr(a_cnt_clr), .underrun_cnt(a_cnt)
`endif
  );

  i2s_stream_tx #(.SAMPLE_W(16), .SLOT_BITS(32), .BCLK_DIV(2), .FIFO_DEPTH(4),
                  .STEREO(0), .UNDERRUN_HOLD(0)) u_b (
    .clk_sys(clk), .reset_n(b_rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_left(b_left), .in_right(b_right), .level(b_level), .underrun(b_ur),
    .i2s_bclk(b_bclk), .i2s_lrclk(b_lr), .i2s_data(b_data)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .cnt_clr(b_cnt_clr), .underrun_cnt(b_cnt)
`endif
  );

  i2s_stream_tx u_d (
    .clk_sys(clk), .reset_n(d_rst_n), .in_valid(d_valid), .in_ready(d_ready),
    .in_left(d_left), .in_right(d_right), .level(d_level), .underrun(d_ur),
    .i2s_bclk(d_bclk), .i2s_lrclk(d_lr), .i2s_data(d_data)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .cnt_clr(d_cnt_clr), .underrun_cnt(d_cnt)
`endif
  );

  // Serial monitor: selects which instance the frame capture watches
  int   sel;
  logic m_bclk, m_lr, m_data, m_ur;
  always_comb begin
    case (sel)
      0:       begin m_bclk = a_bclk; m_lr = a_lr; m_data = a_data; m_ur = a_ur; end
      1:       begin m_bclk = b_bclk; m_lr = b_lr; m_data = b_data; m_ur = b_ur; end
      default: begin m_bclk = d_bclk; m_lr = d_lr; m_data = d_data; m_ur = d_ur; end
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected 64-bit frame, first transmitted bit (left p=0) in bit 63
  function automatic logic [63:0] frm(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  // Waits for the next frame start, then samples 64 bits on BCLK rising edges
  task automatic capture_frame(output logic [63:0] bits, output int ur_cnt, output bit ok);
    logic prev_lr, prev_bclk;
    bit   started;
    int   n;
    bits = 64'h0; ur_cnt = 0; started = 1'b0; n = 0;
    prev_lr = m_lr; prev_bclk = m_bclk;
    for (int cyc = 0; cyc < 1000 && n < 64; cyc++) begin
      @(negedge clk);
      if (started && m_bclk && !prev_bclk) begin
        bits = {bits[62:0], m_data};
        n++;
      end
      if (!started && prev_lr && !m_lr) started = 1'b1;
      if (started && m_ur) ur_cnt++;
      prev_lr = m_lr; prev_bclk = m_bclk;
    end
    ok = (n == 64);
  endtask

  task automatic push_a(input logic [15:0] l, input logic [15:0] r);
    a_valid = 1'b1; a_left = l; a_right = r;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  logic [63:0] bits;
  int          urc;
  bit          ok;
  int          last_rise, rise_per, last_lr_t, lr_per, last_ur_t, ur_per;
  int          ur_hi, data_hi, lvl_nz, wait_cnt;
  logic        prev_b, prev_l;
  bit          found;

  initial begin
    sel = 2;
    a_rst_n = 1'b0; a_valid = 1'b0; a_left = 16'h0; a_right = 16'h0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_left = 16'h0; b_right = 16'h0;
    d_rst_n = 1'b0; d_valid = 1'b0; d_left = 16'h0; d_right = 16'h0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    a_cnt_clr = 1'b0; b_cnt_clr = 1'b0; d_cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // ---- Default parameters: reset state and idle timing ----
    check_eq("d_rst_bclk",  64'(d_bclk),  64'd0);
    check_eq("d_rst_lrclk", 64'(d_lr),    64'd0);
    check_eq("d_rst_data",  64'(d_data),  64'd0);
    check_eq("d_rst_ur",    64'(d_ur),    64'd0);
    check_eq("d_rst_level", 64'(d_level), 64'd0);
    check_eq("d_rst_ready", 64'(d_ready), 64'd1);
    d_rst_n = 1'b1;
    last_rise = -1; rise_per = 0; last_lr_t = -1; lr_per = 0; last_ur_t = -1; ur_per = 0;
    ur_hi = 0; data_hi = 0; lvl_nz = 0;
    prev_b = d_bclk; prev_l = d_lr;
    for (int t = 1; t <= 2100; t++) begin
      @(negedge clk);
      if (d_bclk && !prev_b) begin
        if (last_rise >= 0) rise_per = t - last_rise;
        last_rise = t;
      end
      if (d_lr != prev_l) begin
        if (last_lr_t >= 0) lr_per = t - last_lr_t;
        last_lr_t = t;
      end
      if (d_ur) begin
        ur_hi++;
        if (last_ur_t >= 0) ur_per = t - last_ur_t;
        last_ur_t = t;
      end
      if (d_data) data_hi++;
      if (d_level != 4'd0) lvl_nz++;
      prev_b = d_bclk; prev_l = d_lr;
    end
    check_eq("d_bclk_period", 64'(rise_per), 64'd16);
    check_eq("d_lrclk_half",  64'(lr_per),   64'd512);
    check_eq("d_ur_period",   64'(ur_per),   64'd1024);
    check_eq("d_ur_pulses",   64'(ur_hi),    64'd2);
    check_eq("d_data_idle",   64'(data_hi),  64'd0);
    check_eq("d_level_idle",  64'(lvl_nz),   64'd0);
    d_rst_n = 1'b0;

    // ---- Instance A: framing and hold-on-underrun ----
    sel = 0;
    a_rst_n = 1'b1;
    push_a(16'hA5C3, 16'h0F01);
    push_a(16'h1234, 16'h5678);
    check_eq("a_level_2", 64'(a_level), 64'd2);
    capture_frame(bits, urc, ok);
    check_eq("a_f1_done",  64'(ok),      64'd1);
    check_eq("a_f1_frame", bits,         frm(16'hA5C3, 16'h0F01));
    check_eq("a_f1_left",  64'(bits[62:47]), 64'h0000_0000_0000_A5C3);
    check_eq("a_f1_right", 64'(bits[30:15]), 64'h0000_0000_0000_0F01);
    check_eq("a_f1_ur",    64'(urc),     64'd0);
    capture_frame(bits, urc, ok);
    check_eq("a_f2_frame", bits,         frm(16'h1234, 16'h5678));
    check_eq("a_f2_ur",    64'(urc),     64'd0);
    capture_frame(bits, urc, ok);
    check_eq("a_f3_hold",  bits,         frm(16'h1234, 16'h5678));
    check_eq("a_f3_ur",    64'(urc),     64'd1);
    check_eq("a_f3_level", 64'(a_level), 64'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check_eq("a_cnt_1",    64'(a_cnt),   64'd1);
`endif

    // ---- Instance A: FIFO fill, fetch, reset mid right slot ----
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    a_valid = 1'b1; a_right = 16'hFFFF;
    for (int k = 1; k <= 6; k++) begin
      a_left = 16'(k);
      @(negedge clk);
    end
    a_valid = 1'b0;
    check_eq("a_full_level", 64'(a_level), 64'd4);
    check_eq("a_full_ready", 64'(a_ready), 64'd0);
    found = 1'b0; prev_l = a_lr;
    for (int t = 0; t < 600 && !found; t++) begin
      @(negedge clk);
      if (prev_l && !a_lr) found = 1'b1;
      prev_l = a_lr;
    end
    check_eq("a_fetch_seen",  64'(found),   64'd1);
    check_eq("a_fetch_level", 64'(a_level), 64'd3);
    check_eq("a_fetch_ready", 64'(a_ready), 64'd1);
    found = 1'b0;
    for (int t = 0; t < 600 && !found; t++) begin
      @(negedge clk);
      if (a_lr && a_bclk && a_data) found = 1'b1;
    end
    check_eq("a_mid_right", 64'(found),   64'd1);
    check_eq("a_mid_level", 64'(a_level), 64'd3);
    a_rst_n = 1'b0;
    @(negedge clk);
    check_eq("a_rst_bclk",  64'(a_bclk),  64'd0);
    check_eq("a_rst_lrclk", 64'(a_lr),    64'd0);
    check_eq("a_rst_data",  64'(a_data),  64'd0);
    check_eq("a_rst_level", 64'(a_level), 64'd0);
    check_eq("a_rst_ready", 64'(a_ready), 64'd1);
    check_eq("a_rst_ur",    64'(a_ur),    64'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check_eq("a_rst_cnt",   64'(a_cnt),   64'd0);
`endif
    a_rst_n = 1'b1;
    found = 1'b0; wait_cnt = 0; prev_l = a_lr;
    for (int t = 1; t <= 600 && !found; t++) begin
      @(negedge clk);
      if (prev_l && !a_lr) begin
        found = 1'b1;
        wait_cnt = t;
      end
      prev_l = a_lr;
    end
    check_eq("a_first_fetch_t", 64'(wait_cnt), 64'd256);
    check_eq("a_flush_ur",      64'(a_ur),     64'd1);
    a_rst_n = 1'b0;

    // ---- Instance B: mono duplication and zero-on-underrun ----
    sel = 1;
    b_rst_n = 1'b1;
    b_valid = 1'b1; b_left = 16'h8001; b_right = 16'hFFFF;
    @(negedge clk);
    b_valid = 1'b0;
    check_eq("b_level_1", 64'(b_level), 64'd1);
    capture_frame(bits, urc, ok);
    check_eq("b_f1_frame", bits,     frm(16'h8001, 16'h8001));
    check_eq("b_f1_ur",    64'(urc), 64'd0);
    capture_frame(bits, urc, ok);
    check_eq("b_f2_zero",  bits,     64'h0);
    check_eq("b_f2_ur",    64'(urc), 64'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check_eq("b_cnt_1", 64'(b_cnt), 64'd1);
    b_cnt_clr = 1'b1;
    @(negedge clk);
    b_cnt_clr = 1'b0;
    check_eq("b_cnt_clr", 64'(b_cnt), 64'd0);
`endif
    b_rst_n = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
